// File: rtl/uart_cmd_pkg.sv
// Shared types and helpers for the UART command framer.
package uart_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        CSUM = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_CSUM    = 2'd0,
        ERR_ADDR    = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_UART    = 2'd3
    } err_code_t;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ERR_CNT_MAX       = 8'hFF;

    // Frame checksum: XOR of sync, zero-extended address and data.
    function automatic logic [7:0] frame_csum(input logic [7:0] sync_b,
                                              input logic [7:0] addr_b,
                                              input logic [7:0] data_b);
        return sync_b ^ addr_b ^ data_b;
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte gap watchdog: counts while a frame is open, restarts on every
// accepted byte and flags a single-cycle expiry after TIMEOUT_CYCLES.
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic clk,
    input  logic resetn,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Expiry is suppressed by a same-cycle byte so the byte always wins.
    always_comb begin
        expired = run && !clear && (cnt_q == LAST);
        cnt_d   = cnt_q;
        if (!run || clear || expired) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames the UART byte stream into sync/addr/data/checksum commands and turns
// each valid frame into a digit-write strobe; malformed frames raise errors.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int unsigned  CLK_FREQ   = 50,
    parameter int unsigned  TIMEOUT_US = 1000,
    parameter int unsigned  NUM_DIGITS = 4,
    parameter logic [7:0]   SYNC_BYTE  = DEFAULT_SYNC_BYTE,
    localparam int unsigned AW         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [7:0]    tdata,
    input  logic          tvalid,
    input  logic          tuser,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          err,
    output logic [1:0]    err_code,
    output logic [7:0]    err_cnt
);

    localparam int unsigned TIMEOUT_CYCLES = CLK_FREQ * TIMEOUT_US;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          wr_en_q, wr_en_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          err_q, err_d;
    err_code_t     err_code_q, err_code_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          expired;
    logic          frame_open;
    logic [7:0]    addr8;
    logic [7:0]    csum_exp;
    logic          addr_bad;

    assign frame_open = (state_q != IDLE);

    uart_cmd_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .resetn (resetn),
        .run    (frame_open),
        .clear  (tvalid),
        .expired(expired)
    );

    // Checksum expectation and address range test.
    always_comb begin
        addr8          = '0;
        addr8[AW-1:0]  = addr_q;
        csum_exp       = frame_csum(SYNC_BYTE, addr8, data_q);
        addr_bad       = ({24'd0, tdata} >= NUM_DIGITS);
    end

    // Next-state and registered-output logic; uart error on a byte overrides all
    // other per-byte rules, and any byte overrides a same-cycle timeout.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;

        if (tvalid) begin
            if (tuser) begin
                if (state_q != IDLE) begin
                    err_d      = 1'b1;
                    err_code_d = ERR_UART;
                    state_d    = IDLE;
                end
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (tdata == SYNC_BYTE) begin
                            state_d = ADDR;
                        end
                    end
                    ADDR: begin
                        if (tdata == SYNC_BYTE) begin
                            state_d = ADDR;
                        end else if (addr_bad) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_ADDR;
                            state_d    = IDLE;
                        end else begin
                            addr_d  = tdata[AW-1:0];
                            state_d = DATA;
                        end
                    end
                    DATA: begin
                        data_d  = tdata;
                        state_d = CSUM;
                    end
                    CSUM: begin
                        if (tdata == csum_exp) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = data_q;
                        end else begin
                            err_d      = 1'b1;
                            err_code_d = ERR_CSUM;
                        end
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (expired) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
            state_d    = IDLE;
        end

        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != ERR_CNT_MAX)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_CSUM;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Randomized and directed bench for uart_cmd_parser against a frame-buffer model.
module tb_uart_cmd_parser;

    localparam int unsigned TC   = 100;
    localparam int unsigned NDIG = 4;
    localparam logic [7:0]  SYNC = 8'hA5;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tuser;
    logic       wr_en;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       err;
    logic [1:0] err_code;
    logic [7:0] err_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    uart_cmd_parser #(
        .CLK_FREQ  (50),
        .TIMEOUT_US(2),
        .NUM_DIGITS(4),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .tdata   (tdata),
        .tvalid  (tvalid),
        .tuser   (tuser),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .err     (err),
        .err_code(err_code),
        .err_cnt (err_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: bytes of the open frame ----------------
    logic [7:0] fb[$];
    int         gap;
    bit         m_wr_en, m_err;
    int         m_wr_addr, m_wr_data, m_code, m_cnt;

    task automatic raise(input int code);
        m_err  = 1'b1;
        m_code = code;
        if (m_cnt < 255) m_cnt++;
        fb.delete();
    endtask

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fb.delete();
            gap = 0; m_wr_en = 0; m_err = 0;
            m_wr_addr = 0; m_wr_data = 0; m_code = 0; m_cnt = 0;
        end else begin
            m_wr_en = 0;
            m_err   = 0;
            if (tvalid) begin
                gap = 0;
                if (tuser) begin
                    if (fb.size() != 0) raise(3);
                end else if (fb.size() == 0) begin
                    if (tdata == SYNC) fb.push_back(tdata);
                end else if (fb.size() == 1) begin
                    if (tdata == SYNC) begin
                        // resync: frame restarts, buffer keeps the single sync
                    end else if (int'(tdata) >= NDIG) raise(1);
                    else fb.push_back(tdata);
                end else if (fb.size() == 2) begin
                    fb.push_back(tdata);
                end else begin
                    if ((fb[0] ^ fb[1] ^ fb[2]) == tdata) begin
                        m_wr_en   = 1'b1;
                        m_wr_addr = int'(fb[1]);
                        m_wr_data = int'(fb[2]);
                        fb.delete();
                    end else raise(0);
                end
            end else if (fb.size() != 0) begin
                gap++;
                if (gap == TC) begin
                    raise(2);
                    gap = 0;
                end
            end
        end
    end

    // ---------------- per-cycle compare and event capture ----------------
    int wr_seen = 0, err_seen = 0;
    int last_addr = -1, last_data = -1, last_code = -1, err_cyc = -1;

    always @(negedge clk) begin
        chk("wr_en",    int'(wr_en),    int'(m_wr_en));
        chk("err",      int'(err),      int'(m_err));
        chk("wr_addr",  int'(wr_addr),  m_wr_addr);
        chk("wr_data",  int'(wr_data),  m_wr_data);
        chk("err_code", int'(err_code), m_code);
        chk("err_cnt",  int'(err_cnt),  m_cnt);
        chk("wr_err_excl", int'(wr_en && err), 0);
        if (wr_en) begin
            wr_seen++;
            last_addr = int'(wr_addr);
            last_data = int'(wr_data);
        end
        if (err) begin
            err_seen++;
            last_code = int'(err_code);
            err_cyc   = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input bit v, input bit u, input logic [7:0] d);
        @(posedge clk);
        #1;
        tvalid = v;
        tuser  = u;
        tdata  = d;
    endtask

    task automatic send(input logic [7:0] d);
        drive(1'b1, 1'b0, d);
    endtask

    task automatic settle();
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b0, 1'b0, 8'h00);
    endtask

    int w0, e0, c0;
    logic [7:0] fr[$];

    initial begin
        resetn = 1'b0;
        tvalid = 1'b0;
        tuser  = 1'b0;
        tdata  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en",   int'(wr_en),   0);
        chk("rst_err",     int'(err),     0);
        chk("rst_err_cnt", int'(err_cnt), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        resetn = 1'b1;

        // Good frame
        w0 = wr_seen; e0 = err_seen;
        send(8'hA5); send(8'h02); send(8'h3C); send(8'h9B); settle();
        chk("good_wr_count", wr_seen - w0, 1);
        chk("good_addr", last_addr, 2);
        chk("good_data", last_data, 8'h3C);
        chk("good_no_err", err_seen - e0, 0);
        chk("good_err_cnt", int'(err_cnt), 0);

        // Bad checksum then corrected frame
        e0 = err_seen;
        send(8'hA5); send(8'h01); send(8'h10); send(8'h00); settle();
        chk("csum_err", err_seen - e0, 1);
        chk("csum_code", last_code, 0);
        chk("csum_err_cnt", int'(err_cnt), 1);
        w0 = wr_seen;
        send(8'hA5); send(8'h01); send(8'h10); send(8'hB4); settle();
        chk("csum_fix_wr", wr_seen - w0, 1);
        chk("csum_fix_addr", last_addr, 1);
        chk("csum_fix_data", last_data, 8'h10);

        // Address out of range, then leading garbage
        e0 = err_seen;
        send(8'hA5); send(8'h07); settle();
        chk("addr_code", last_code, 1);
        send(8'h3C); send(8'h9B); settle();
        chk("addr_err_once", err_seen - e0, 1);
        chk("addr_err_cnt", int'(err_cnt), 2);

        // Resync
        w0 = wr_seen; e0 = err_seen;
        send(8'hA5); send(8'hA5); send(8'h01); send(8'h55); send(8'hF1); settle();
        chk("resync_wr", wr_seen - w0, 1);
        chk("resync_addr", last_addr, 1);
        chk("resync_data", last_data, 8'h55);
        chk("resync_no_err", err_seen - e0, 0);

        // Timeout after byte 02
        e0 = err_seen;
        send(8'hA5); send(8'h02);
        c0 = cyc + 1;
        repeat (150) drive(1'b0, 1'b0, 8'h00);
        chk("tmo_err_seen", err_seen - e0, 1);
        chk("tmo_code", last_code, 2);
        chk("tmo_latency_ok", int'((err_cyc - c0) >= 99 && (err_cyc - c0) <= 101), 1);

        // Byte arriving on the last cycle before expiry is accepted
        e0 = err_seen; w0 = wr_seen;
        send(8'hA5); send(8'h02);
        repeat (TC - 1) drive(1'b0, 1'b0, 8'h00);
        send(8'h3C); send(8'h9B); settle();
        chk("tmo_edge_no_err", err_seen - e0, 0);
        chk("tmo_edge_wr", wr_seen - w0, 1);
        chk("tmo_edge_data", last_data, 8'h3C);

        // UART error on third byte
        e0 = err_seen;
        send(8'hA5); send(8'h02); drive(1'b1, 1'b1, 8'h3C); settle();
        chk("uart_err", err_seen - e0, 1);
        chk("uart_code", last_code, 3);

        // Asynchronous reset mid-frame
        send(8'hA5); send(8'h01);
        @(posedge clk);
        #2;
        tvalid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("arst_wr_addr", int'(wr_addr), 0);
        chk("arst_wr_data", int'(wr_data), 0);
        chk("arst_err_code", int'(err_code), 0);
        chk("arst_err_cnt", int'(err_cnt), 0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        w0 = wr_seen;
        send(8'hA5); send(8'h03); send(8'h77); send(8'hD1); settle();
        chk("post_rst_wr", wr_seen - w0, 1);
        chk("post_rst_addr", last_addr, 3);
        chk("post_rst_data", last_data, 8'h77);

        // Error counter saturation
        e0 = err_seen;
        for (int i = 0; i < 300; i++) begin
            send(8'hA5); send(8'h01); send(8'h10); send(8'h00);
        end
        settle();
        chk("sat_err_pulses", err_seen - e0, 300);
        chk("sat_err_cnt", int'(err_cnt), 255);

        // Randomized traffic
        for (int f = 0; f < 400; f++) begin
            int          kind;
            logic [7:0]  a, d;
            kind = int'($urandom_range(0, 9));
            a = 8'($urandom_range(0, NDIG - 1));
            d = 8'($urandom);
            fr.delete();
            case (kind)
                0, 1, 2, 3: fr = '{SYNC, a, d, SYNC ^ a ^ d};
                4:          fr = '{SYNC, a, d, 8'($urandom)};
                5:          fr = '{SYNC, 8'($urandom_range(NDIG, 255)), d};
                6:          fr = '{8'($urandom), 8'($urandom)};
                7:          fr = '{SYNC, SYNC, a, d, SYNC ^ a ^ d};
                8:          fr = '{SYNC, a, SYNC, SYNC ^ a ^ SYNC};
                default:    fr = '{SYNC, a};
            endcase
            foreach (fr[k]) begin
                int gsel;
                int glen;
                gsel = int'($urandom_range(0, 99));
                glen = (gsel < 80) ? 0 : (gsel < 95) ? int'($urandom_range(1, 4))
                                                     : int'($urandom_range(TC - 3, TC + 3));
                repeat (glen) drive(1'b0, 1'($urandom), 8'($urandom));
                drive(1'b1, ($urandom_range(0, 29) == 0), fr[k]);
            end
        end
        repeat (TC + 10) drive(1'b0, 1'b0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
